// File: rtl/ps2mouse_cursor_track_if.sv
// Packet-in / cursor-out bundle for ps2mouse_cursor_track.
// master drives packets and recentre; slave is the cursor tracker.
interface ps2mouse_cursor_track_if;
  logic        iTrig;
  logic [31:0] iData;
  logic        iClr;
  logic        oTrig;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic [2:0]  oBtn;
  logic [2:0]  oClick;
  logic        oLost;
  logic [7:0]  oZ;

  modport master (
    output iTrig, iData, iClr,
    input  oTrig, oX, oY, oBtn, oClick, oLost, oZ
  );

  modport slave (
    input  iTrig, iData, iClr,
    output oTrig, oX, oY, oBtn, oClick, oLost, oZ
  );
endinterface

// File: rtl/ps2mouse_cursor_track.sv
// Converts decoded PS/2 mouse packets into a clamped absolute cursor, button levels and click pulses.
// Optional wheel accumulator on oZ is built only when PS2MOUSE_WHEEL_EN is defined.
module ps2mouse_cursor_track #(
  parameter int H_MAX       = 639,
  parameter int V_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int SPEED_SHIFT = 0
) (
  input logic CLOCK,
  input logic RST,
  ps2mouse_cursor_track_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_CALC, S_COMMIT} state_t;

  localparam logic signed [12:0] H_MAX_S = 13'(H_MAX);
  localparam logic signed [12:0] V_MAX_S = 13'(V_MAX);

  state_t             state, state_nx;
  logic               take_in, take_pend, store, drop;
  logic               do_latch, do_calc, do_commit;
  logic               pend_valid;
  logic [31:0]        pend_data;
  logic [31:0]        pkt;
  logic signed [12:0] dx, dy;
  logic [2:0]         btn_lat;
  logic [9:0]         x_calc, y_calc;
  logic signed [12:0] x_sum, y_sum;

  function automatic logic signed [12:0] axis_delta(input logic [7:0] mag,
                                                    input logic sgn, input logic ovf);
    logic signed [12:0] d;
    d = ovf ? 13'sd0 : {{4{sgn}}, sgn, mag};
    return d <<< SPEED_SHIFT;
  endfunction

  function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                       input logic signed [12:0] hi);
    if (v < 13'sd0)  return 10'd0;
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (bus.iTrig) state_nx = S_LATCH;
      S_LATCH:  state_nx = S_CALC;
      S_CALC:   state_nx = S_COMMIT;
      S_COMMIT: state_nx = (pend_valid || bus.iTrig) ? S_LATCH : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (bus.iClr) state_nx = S_IDLE;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    take_in   = 1'b0;
    take_pend = 1'b0;
    store     = 1'b0;
    drop      = 1'b0;
    do_latch  = 1'b0;
    do_calc   = 1'b0;
    do_commit = 1'b0;
    unique case (state)
      S_IDLE: take_in = bus.iTrig;
      S_LATCH, S_CALC: begin
        do_latch = (state == S_LATCH);
        do_calc  = (state == S_CALC);
        store    = bus.iTrig && !pend_valid;
        drop     = bus.iTrig && pend_valid;
      end
      S_COMMIT: begin
        // A trigger arriving in COMMIT with an empty buffer passes straight through to LATCH.
        do_commit = 1'b1;
        take_pend = pend_valid;
        take_in   = bus.iTrig && !pend_valid;
        drop      = bus.iTrig && pend_valid;
      end
      default: ;
    endcase
    if (bus.iClr) begin
      take_in   = 1'b0;
      take_pend = 1'b0;
      store     = 1'b0;
      drop      = 1'b0;
      do_latch  = 1'b0;
      do_calc   = 1'b0;
      do_commit = 1'b0;
    end
  end

  assign x_sum = $signed({3'b000, bus.oX}) + dx;
  assign y_sum = $signed({3'b000, bus.oY}) - dy;

  // NOTE: datapath registers are reset too, so no X ever reaches the cursor outputs.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      bus.oX     <= 10'(X_INIT);
      bus.oY     <= 10'(Y_INIT);
      bus.oBtn   <= 3'b000;
      bus.oClick <= 3'b000;
      bus.oTrig  <= 1'b0;
      bus.oLost  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pkt        <= '0;
      dx         <= '0;
      dy         <= '0;
      btn_lat    <= '0;
      x_calc     <= '0;
      y_calc     <= '0;
    end else if (bus.iClr) begin
      bus.oX     <= 10'(X_INIT);
      bus.oY     <= 10'(Y_INIT);
      bus.oClick <= 3'b000;
      bus.oTrig  <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      bus.oTrig  <= do_commit;
      bus.oClick <= do_commit ? (btn_lat & ~bus.oBtn) : 3'b000;

      if (take_in)        pkt <= bus.iData;
      else if (take_pend) pkt <= pend_data;

      if (store) begin
        pend_valid <= 1'b1;
        pend_data  <= bus.iData;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end

      if (drop) bus.oLost <= 1'b1;

      if (do_latch) begin
        dx      <= axis_delta(pkt[15:8],  pkt[4], pkt[6]);
        dy      <= axis_delta(pkt[23:16], pkt[5], pkt[7]);
        btn_lat <= pkt[2:0];
      end

      if (do_calc) begin
        x_calc <= clamp(x_sum, H_MAX_S);
        y_calc <= clamp(y_sum, V_MAX_S);
      end

      if (do_commit) begin
        bus.oX   <= x_calc;
        bus.oY   <= y_calc;
        bus.oBtn <= btn_lat;
      end
    end
  end

`ifdef PS2MOUSE_WHEEL_EN
  logic signed [3:0] dz;
  logic signed [7:0] z;
  logic signed [8:0] z_sum;
  logic [4:0]        unused_bits;

  assign z_sum       = {z[7], z} + {{5{dz[3]}}, dz};
  assign bus.oZ      = z;
  assign unused_bits = {pkt[31:28], pkt[3]};

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      dz <= '0;
      z  <= '0;
    end else if (bus.iClr) begin
      z  <= '0;
    end else begin
      if (do_latch) dz <= pkt[27:24];
      if (do_commit) begin
        if (z_sum > 9'sd127)       z <= 8'sd127;
        else if (z_sum < -9'sd128) z <= -8'sd128;
        else                       z <= z_sum[7:0];
      end
    end
  end
`else
  logic [8:0] unused_bits;

  assign bus.oZ      = 8'd0;
  assign unused_bits = {pkt[31:24], pkt[3]};
`endif

endmodule

// File: tb/tb_ps2mouse_cursor_track.sv
// Self-checking bench for ps2mouse_cursor_track: directed scenarios plus random packets vs a behavioural model.
// Honours PS2MOUSE_WHEEL_EN the same way the design does.
module tb_ps2mouse_cursor_track;

  localparam int H_MAX = 639, V_MAX = 479, X_INIT = 320, Y_INIT = 240, SHIFT = 0;

  logic CLOCK = 1'b0;
  logic RST   = 1'b1;
  ps2mouse_cursor_track_if bus ();

  ps2mouse_cursor_track #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .SPEED_SHIFT(SHIFT)
  ) dut (
    .CLOCK(CLOCK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the cursor state.
  int         mx = X_INIT, my = Y_INIT, mz = 0;
  logic [2:0] mbtn = 3'b000, mclick = 3'b000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(input logic [7:0] b, input logic sgn, input logic ovf);
    int d;
    if (ovf) return 0;
    d = sgn ? int'(b) - 256 : int'(b);
    return d * (1 << SHIFT);
  endfunction

  task automatic model_apply(input logic [31:0] d);
    logic [7:0] st;
    int w;
    st     = d[7:0];
    mx     = clampi(mx + delta(d[15:8], st[4], st[6]), 0, H_MAX);
    my     = clampi(my - delta(d[23:16], st[5], st[7]), 0, V_MAX);
    mclick = st[2:0] & ~mbtn;
    mbtn   = st[2:0];
`ifdef PS2MOUSE_WHEEL_EN
    w  = d[27] ? int'(d[27:24]) - 16 : int'(d[27:24]);
    mz = clampi(mz + w, -128, 127);
`else
    w  = 0;
    mz = mz + w;
`endif
  endtask

  task automatic check_state(input string tag);
    logic [7:0] ez;
    ez = 8'(mz);
    check({tag, "_x"},     bus.oX,     mx);
    check({tag, "_y"},     bus.oY,     my);
    check({tag, "_btn"},   bus.oBtn,   mbtn);
    check({tag, "_click"}, bus.oClick, mclick);
    check({tag, "_z"},     bus.oZ,     ez);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_and_check(input logic [31:0] d, input string tag);
    int lat;
    bus.iTrig = 1'b1;
    bus.iData = d;
    tick();
    bus.iTrig = 1'b0;
    lat = 0;
    while (bus.oTrig !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    model_apply(d);
    check_state(tag);
    tick();
    check({tag, "_trig_low"},  bus.oTrig,  0);
    check({tag, "_click_low"}, bus.oClick, 0);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(tag, bus.oTrig, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (oTrig=%0b)", bus.oTrig);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pa, pb, pc;
    bus.iTrig = 1'b0;
    bus.iData = '0;
    bus.iClr  = 1'b0;

    #12;
    check("rst_x",     bus.oX,     X_INIT);
    check("rst_y",     bus.oY,     Y_INIT);
    check("rst_btn",   bus.oBtn,   0);
    check("rst_click", bus.oClick, 0);
    check("rst_trig",  bus.oTrig,  0);
    check("rst_lost",  bus.oLost,  0);
    check("rst_z",     bus.oZ,     0);
    @(negedge CLOCK);
    RST = 1'b0;
    tick();

    // Basic move and clamping against both X limits.
    send_and_check(32'h0003_0500, "move");
    check("move_x325", bus.oX, 325);
    check("move_y237", bus.oY, 237);
    send_and_check(32'h0000_0010, "left256");
    send_and_check(32'h0000_C010, "left64");
    check("at_x5", bus.oX, 5);
    send_and_check(32'h0000_F610, "clamp_lo");
    check("clamp_lo_x0", bus.oX, 0);
    send_and_check(32'h0000_FF00, "right255a");
    send_and_check(32'h0000_FF00, "right255b");
    send_and_check(32'h0000_5A00, "right90");
    check("at_x600", bus.oX, 600);
    send_and_check(32'h0000_FF00, "clamp_hi");
    check("clamp_hi_x639", bus.oX, H_MAX);

    // Overflow masks the delta; a held button clicks only once.
    send_and_check(32'h0000_8041, "ovf_press");
    check("ovf_press_click", mclick, 3'b001);
    send_and_check(32'h0000_8041, "ovf_hold");
    check("ovf_hold_click", mclick, 3'b000);

    // Y clamping both ways.
    send_and_check(32'h0000_0020, "down256");
    send_and_check(32'h0000_0020, "down_clamp");
    send_and_check(32'h00FF_0000, "up255");
    send_and_check(32'h00FF_0000, "up_clamp");

    // Trigger landing in the COMMIT cycle goes straight through without an IDLE gap.
    pa = 32'h0011_2202;
    pb = 32'h0033_4404;
    bus.iTrig = 1'b1; bus.iData = pa;
    tick();
    bus.iTrig = 1'b0;
    tick();
    tick();
    bus.iTrig = 1'b1; bus.iData = pb;
    tick();
    bus.iTrig = 1'b0;
    check("cmt_a_trig", bus.oTrig, 1);
    model_apply(pa);
    check_state("cmt_a");
    for (int k = 4; k <= 6; k++) begin
      tick();
      check("cmt_b_trig", bus.oTrig, (k == 6) ? 1 : 0);
    end
    model_apply(pb);
    check_state("cmt_b");
    tick();

    // Random isolated packets.
    for (int i = 0; i < 30; i++) send_and_check($urandom, "rand");
    check("no_lost_yet", bus.oLost, 0);

    // Back-to-back: first two processed, third dropped and flagged.
    pa = 32'h0002_0300 | ($urandom & 32'h0F00_0007);
    pb = 32'h0004_0700 | ($urandom & 32'h0F00_0007);
    pc = 32'h0000_1000;
    bus.iTrig = 1'b1; bus.iData = pa;
    tick();
    bus.iData = pb;
    tick();
    bus.iData = pc;
    tick();
    bus.iTrig = 1'b0;
    check("b2b_lost", bus.oLost, 1);
    check("b2b_trig_early", bus.oTrig, 0);
    tick();
    check("b2b_a_trig", bus.oTrig, 1);
    model_apply(pa);
    check_state("b2b_a");
    for (int k = 4; k <= 6; k++) begin
      tick();
      check("b2b_b_trig", bus.oTrig, (k == 6) ? 1 : 0);
    end
    model_apply(pb);
    check_state("b2b_b");
    expect_quiet(5, "b2b_c_dropped");

    // Recentre during CALC discards the packet and keeps buttons and the lost flag.
    send_and_check(32'h0000_4001, "pre_clr");
    bus.iTrig = 1'b1; bus.iData = 32'h0000_2007;
    tick();
    bus.iTrig = 1'b0;
    tick();
    bus.iClr = 1'b1;
    tick();
    bus.iClr = 1'b0;
    mx = X_INIT; my = Y_INIT; mz = 0; mclick = 3'b000;
    check_state("clr");
    check("clr_lost_kept", bus.oLost, 1);
    expect_quiet(6, "clr_no_trig");
    check("clr_x_stays", bus.oX, X_INIT);

    // Trigger coinciding with recentre is discarded.
    send_and_check(32'h0000_0500, "pre_clr2");
    bus.iTrig = 1'b1; bus.iData = 32'h0000_3000; bus.iClr = 1'b1;
    tick();
    bus.iTrig = 1'b0; bus.iClr = 1'b0;
    mx = X_INIT; my = Y_INIT; mz = 0;
    check_state("clr_trig");
    expect_quiet(6, "clr_trig_quiet");

    // Wheel accumulation and saturation.
    for (int i = 0; i < 20; i++) send_and_check(32'h0700_0000, "wheel_up");
`ifdef PS2MOUSE_WHEEL_EN
    check("wheel_sat", bus.oZ, 8'd127);
`else
    check("wheel_off", bus.oZ, 8'd0);
`endif
    send_and_check(32'h0800_0000, "wheel_down");
`ifdef PS2MOUSE_WHEEL_EN
    check("wheel_119", bus.oZ, 8'd119);
`else
    check("wheel_off2", bus.oZ, 8'd0);
`endif
    check("lost_sticky", bus.oLost, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2mouse_cursor_track.md
Name: ps2mouse_cursor_track

Overview:
Consumes decoded mouse packets (oTrig/oData) from the PS/2 mouse base module. Turns the relative X/Y deltas into an absolute cursor position clamped to a screen window, and tracks button state. Emits one update strobe per processed packet for the display/overlay logic downstream.

Parameters:
H_MAX, 639, largest X coordinate (inclusive); X range 0..H_MAX
V_MAX, 479, largest Y coordinate (inclusive); Y range 0..V_MAX
X_INIT, 320, X position after reset or iClr
Y_INIT, 240, Y position after reset or iClr
SPEED_SHIFT, 0, delta is left-shifted by this amount (0..3) before accumulation

Ports:
CLOCK  in  1  system clock
RST  in  1  asynchronous, active-high reset
iTrig  in  1  one-cycle packet-valid strobe from the mouse base module
iData  in  32  packet: [7:0] status, [15:8] X delta, [23:16] Y delta, [31:24] wheel byte
iClr  in  1  synchronous recentre request, one-cycle pulse
oTrig  out  1  one-cycle pulse: position/buttons updated
oX  out  10  cursor X, 0..H_MAX
oY  out  10  cursor Y, 0..V_MAX (screen-down positive)
oBtn  out  3  {M,R,L} current button levels
oClick  out  3  {M,R,L} rising-edge pulses, valid only with oTrig
oLost  out  1  sticky: a packet was dropped
oZ  out  8  signed wheel accumulator (see Optional Feature)

Behaviour:
- Reset (RST=1, async): oX=X_INIT, oY=Y_INIT, oBtn=0, oClick=0, oTrig=0, oLost=0, oZ=0, FSM=IDLE, pending buffer empty.
- Status byte: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
- Delta = 9-bit two's complement {sign, byte}, range -256..255. If overflow bit is set, that axis delta = 0. Then shifted left by SPEED_SHIFT. Sums are computed in 13-bit signed.
- X_new = oX + dX. Y_new = oY - dY (PS/2 Y is up-positive). Each is clamped: <0 -> 0, >MAX -> MAX.
- FSM: IDLE -> LATCH -> CALC -> COMMIT -> IDLE.
  - IDLE: on iTrig, capture iData and go to LATCH.
  - LATCH: sign-extend, apply the overflow mask and the shift.
  - CALC: add and clamp.
  - COMMIT: register oX/oY/oBtn, oClick = new_btn & ~old_btn, and oTrig=1 for exactly that cycle.
- Latency: iTrig sampled at edge N gives outputs updated and oTrig high after edge N+3. oClick is zero whenever oTrig=0.
- One-deep pending buffer:
  - An iTrig while the FSM is not IDLE is stored in the pending buffer.
  - On leaving COMMIT, a pending packet goes straight to LATCH (no IDLE cycle) and the buffer empties.
  - An iTrig while pending is already full is dropped and sets oLost=1, held until RST.
  - An iTrig in the COMMIT cycle itself is accepted into pending if pending is empty.
- iClr (priority over everything except RST):
  - Next edge: oX=X_INIT, oY=Y_INIT, oZ=0, FSM=IDLE, pending cleared, in-flight packet discarded, no oTrig.
  - oBtn and oLost are retained.
  - An iTrig in the same cycle as iClr is discarded.
- Zero-delta packets still produce oTrig, so button changes propagate.

Optional Feature:
Macro PS2MOUSE_WHEEL_EN.
- Defined: wheel delta = sign-extended iData[27:24] (-8..7). In COMMIT, oZ = oZ + delta, saturating to -128..127 (no wrap). oZ is cleared by RST and iClr.
- Not defined: iData[31:24] is ignored and oZ is constant 0; no accumulator logic is built.

Test Plan:
- Reset release, then a packet of status 0x00, X=0x05, Y=0x03 -> after 3 edges oTrig pulses once; oX=325, oY=237, oBtn=0.
- Status 0x10, X=0xF6 (dX=-10) at oX=5 -> oX=0 (clamped low). Status 0x00, X=0xFF at oX=600 -> oX=639.
- Status 0x41 (X overflow, L pressed), X=0x80 -> oX unchanged, oBtn=001, oClick=001. Repeat with identical packet -> oClick=000.
- Three iTrig one cycle apart -> first and second processed (two oTrig pulses, second immediately after the first's COMMIT), third dropped, oLost=1.
- iClr asserted in the CALC cycle of a packet X=0x20 -> oX=320, oY=240, no oTrig for that packet; oBtn unchanged.
- PS2MOUSE_WHEEL_EN defined: 20 packets with iData[27:24]=0x7 -> oZ=127 (saturated); one packet with 0x8 -> oZ=119. Without the macro, oZ stays 0.
